// File: rtl/butterfly_serializer.sv
// Parallel-to-serial output stage: one m-word message in, m n-bit words out, MSW first.
// Optional `send_last` framing output is enabled by defining BUTTERFLY_SERIALIZER_LAST_EN.
module butterfly_serializer #(
   parameter int n = 32,
   parameter int m = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           recv_val,
   output logic           recv_rdy,
   input  logic [m*n-1:0] recv_msg,
   output logic           send_val,
   input  logic           send_rdy,
   output logic [n-1:0]   send_msg
`ifdef BUTTERFLY_SERIALIZER_LAST_EN
   ,
   output logic           send_last
`endif
);

   localparam int IW = (m > 1) ? $clog2(m) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(m - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q, state_d;
   // Ascending packed range puts word 0 in the most significant slot of recv_msg.
   logic [0:m-1][n-1:0] buf_q;
   logic [IW-1:0]       idx_q;
   logic                is_last;
   logic                accept;
   logic                advance;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      state_d  = state_q;
      recv_rdy = 1'b0;
      send_val = 1'b0;
      send_msg = '0;
      accept   = 1'b0;
      advance  = 1'b0;
      is_last  = (idx_q == LAST_IDX);
      // Outputs are forced quiet while reset is held low.
      if (reset) begin
         unique case (state_q)
            IDLE: begin
               recv_rdy = 1'b1;
               if (recv_val) state_d = SEND;
            end
            SEND: begin
               send_val = 1'b1;
               send_msg = buf_q[idx_q];
               // Reload on the final word keeps back-to-back messages bubble-free.
               recv_rdy = is_last && send_rdy;
               if (send_rdy && is_last && !recv_val) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         accept  = recv_val && recv_rdy;
         advance = send_val && send_rdy && !is_last;
      end
   end

`ifdef BUTTERFLY_SERIALIZER_LAST_EN
   assign send_last = send_val && is_last;
`endif

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            buf_q <= recv_msg;
            idx_q <= '0;
         end else if (advance) begin
            idx_q <= idx_q + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_butterfly_serializer.sv
// Scoreboard bench for butterfly_serializer: directed framing/backpressure/reset cases,
// an m=1 instance, and a randomized val/rdy soak against a word-queue reference model.
module tb_butterfly_serializer;

   localparam int N  = 32;
   localparam int M  = 4;
   localparam int N1 = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic           recv_val = 1'b0;
   logic           recv_rdy;
   logic [M*N-1:0] recv_msg = '0;
   logic           send_val;
   logic           send_rdy = 1'b0;
   logic [N-1:0]   send_msg;

   logic           r1_val = 1'b0;
   logic           r1_rdy;
   logic [N1-1:0]  r1_msg = '0;
   logic           s1_val;
   logic           s1_rdy = 1'b0;
   logic [N1-1:0]  s1_msg;

`ifdef BUTTERFLY_SERIALIZER_LAST_EN
   logic send_last;
   logic s1_last;
`endif

   butterfly_serializer #(.n(N), .m(M)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .recv_msg (recv_msg),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .send_msg (send_msg)
`ifdef BUTTERFLY_SERIALIZER_LAST_EN
      ,
      .send_last(send_last)
`endif
   );

   butterfly_serializer #(.n(N1), .m(1)) u_dut1 (
      .clk      (clk),
      .reset    (reset),
      .recv_val (r1_val),
      .recv_rdy (r1_rdy),
      .recv_msg (r1_msg),
      .send_val (s1_val),
      .send_rdy (s1_rdy),
      .send_msg (s1_msg)
`ifdef BUTTERFLY_SERIALIZER_LAST_EN
      ,
      .send_last(s1_last)
`endif
   );

   typedef struct {
      logic [N-1:0] word;
      logic         last;
   } exp_t;

   exp_t exp_q[$];
   exp_t acc_e;
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   n_words = 0;
   int   n_msgs = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: an accepted message becomes M words, MSW first, last flag on word M-1.
   always @(negedge clk) begin
      if (reset && recv_val && recv_rdy) begin
         n_msgs++;
         for (int k = 0; k < M; k++) begin
            acc_e.word = N'(recv_msg >> ((M - 1 - k) * N));
            acc_e.last = (k == M - 1);
            exp_q.push_back(acc_e);
         end
      end
   end

   logic         stall_q = 1'b0;
   logic [N-1:0] stall_msg = '0;

   always @(negedge clk) begin
      if (!reset) begin
         check("reset send_val", send_val, 0);
         check("reset recv_rdy", recv_rdy, 0);
         check("reset send_msg", send_msg, 0);
         check("reset m1 send_val", s1_val, 0);
`ifdef BUTTERFLY_SERIALIZER_LAST_EN
         check("reset send_last", send_last, 0);
`endif
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("stall hold val", send_val, 1);
            check("stall hold msg", send_msg, stall_msg);
         end
         if (send_val && send_rdy) begin
            n_words++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected word: got %0h expected none at %0t", send_msg, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("scoreboard data", send_msg, mon_e.word);
`ifdef BUTTERFLY_SERIALIZER_LAST_EN
               check("scoreboard last", send_last, mon_e.last);
`endif
            end
         end
         stall_q   = send_val && !send_rdy;
         stall_msg = send_msg;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [N-1:0]   w1 [M];
   logic [M*N-1:0] msg_a, msg_b;
   int             w;

   initial begin
      w1[0] = 32'h11111111; w1[1] = 32'h22222222;
      w1[2] = 32'h33333333; w1[3] = 32'h44444444;

      tick(); tick(); tick();
      reset = 1'b1;
      @(negedge clk);
      check("idle recv_rdy", recv_rdy, 1);
      check("idle send_val", send_val, 0);

      // Single message, fixed pattern.
      tick();
      recv_val = 1'b1;
      recv_msg = 128'h11111111_22222222_33333333_44444444;
      send_rdy = 1'b1;
      @(negedge clk);
      check("single accept rdy", recv_rdy, 1);
      tick();
      recv_val = 1'b0;
      for (int k = 0; k < M; k++) begin
         @(negedge clk);
         check("single val", send_val, 1);
         check("single word", send_msg, w1[k]);
`ifdef BUTTERFLY_SERIALIZER_LAST_EN
         check("single last", send_last, (k == M - 1));
`endif
         tick();
      end
      @(negedge clk);
      check("single end val", send_val, 0);

      // Back-to-back messages, recv_val held high across the boundary.
      msg_a = {$urandom, $urandom, $urandom, $urandom};
      msg_b = {$urandom, $urandom, $urandom, $urandom};
      tick();
      recv_val = 1'b1;
      recv_msg = msg_a;
      @(negedge clk);
      check("b2b accept rdy", recv_rdy, 1);
      tick();
      recv_msg = msg_b;
      for (int k = 0; k < 2 * M; k++) begin
         @(negedge clk);
         check("b2b val", send_val, 1);
         check("b2b word", send_msg, N'(((k < M) ? msg_a : msg_b) >> ((M - 1 - (k % M)) * N)));
         check("b2b recv_rdy", recv_rdy, (k % M == M - 1));
         tick();
         if (k == M - 1) recv_val = 1'b0;
      end
      @(negedge clk);
      check("b2b end val", send_val, 0);

      // Backpressure with send_rdy pattern 1,0,0,1.
      msg_a = {$urandom, $urandom, $urandom, $urandom};
      tick();
      recv_val = 1'b1;
      recv_msg = msg_a;
      @(negedge clk);
      tick();
      recv_val = 1'b0;
      w = 0;
      for (int c = 0; c < 40 && w < M; c++) begin
         send_rdy = !((c % 4 == 1) || (c % 4 == 2));
         @(negedge clk);
         check("bp val", send_val, 1);
         check("bp word", send_msg, N'(msg_a >> ((M - 1 - w) * N)));
         check("bp recv_rdy", recv_rdy, (send_rdy && w == M - 1));
         if (send_rdy) w++;
         tick();
      end
      check("bp word count", w, M);
      send_rdy = 1'b1;
      @(negedge clk);
      check("bp end val", send_val, 0);

      // Reset after word 1 transfers; words 2-3 must never appear.
      msg_a = {$urandom, $urandom, $urandom, $urandom};
      tick();
      recv_val = 1'b1;
      recv_msg = msg_a;
      @(negedge clk);
      tick();
      recv_val = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid reset val", send_val, 0);
      check("mid reset rdy", recv_rdy, 0);
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("post reset rdy", recv_rdy, 1);
      check("post reset val", send_val, 0);
      repeat (4) begin
         tick();
         @(negedge clk);
         check("post reset quiet", send_val, 0);
      end

      // m = 1 instance: three single-word messages back to back.
      tick();
      r1_val = 1'b1;
      r1_msg = 16'hAAAA;
      s1_rdy = 1'b1;
      @(negedge clk);
      check("m1 accept rdy", r1_rdy, 1);
      tick();
      r1_msg = 16'h5555;
      @(negedge clk);
      check("m1 val 0", s1_val, 1);
      check("m1 word 0", s1_msg, 16'hAAAA);
      check("m1 reload rdy", r1_rdy, 1);
      tick();
      r1_msg = 16'h0001;
      @(negedge clk);
      check("m1 val 1", s1_val, 1);
      check("m1 word 1", s1_msg, 16'h5555);
      tick();
      r1_val = 1'b0;
      @(negedge clk);
      check("m1 val 2", s1_val, 1);
      check("m1 word 2", s1_msg, 16'h0001);
`ifdef BUTTERFLY_SERIALIZER_LAST_EN
      check("m1 last", s1_last, 1);
`endif
      tick();
      @(negedge clk);
      check("m1 end val", s1_val, 0);

      // Random val/rdy soak.
      tick();
      n_words = 0;
      n_msgs = 0;
      for (int c = 0; c < 10000; c++) begin
         recv_val = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < M; i++) recv_msg[i*N +: N] = $urandom;
         send_rdy = ($urandom_range(0, 4) != 0);
         tick();
      end
      recv_val = 1'b0;
      send_rdy = 1'b1;
      repeat (M + 2) tick();
      @(negedge clk);
      check("soak drained", exp_q.size(), 0);
      check("soak word count", n_words, n_msgs * M);
      check("soak traffic", (n_msgs > 100), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
